gf180mcu_fd_sc_mcu9t5v0__addf_serial: RTL
=========================================

# gf180mcu_fd_sc_mcu9t5v0__addf_serial

Bit-serial adder stage built around the library full-adder cell (`addf`). It accepts two WIDTH-bit operands and a carry-in through a valid/ready handshake. It then feeds one bit pair per clock, LSB first, into a single `addf` bit slice, with the carry held in a reset-low flop. The assembled sum and carry-out are presented to the downstream consumer through a second valid/ready handshake.

## Interface

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 2..32.

Ports:
- CLK  input  1  rising-edge clock; the only clock.
- RN  input  1  asynchronous active-low reset.
- IN_VALID  input  1  operand set A/B/CI valid.
- IN_READY  output  1  block can accept an operand set.
- A  input  WIDTH  addend.
- B  input  WIDTH  addend.
- CI  input  1  carry-in.
- OUT_VALID  output  1  S/CO hold a completed result.
- OUT_READY  input  1  consumer takes the result.
- S  output  WIDTH  sum, registered.
- CO  output  1  carry-out, registered.

## Operation

- Function: {CO,S} = A + B + CI, modulo 2^(WIDTH+1).
- Datapath elements:
  - One `addf` instance computes the bit slice from a_sh[0], b_sh[0] and carry.
  - a_sh and b_sh are WIDTH-bit right-shift registers.
  - s_sh is a WIDTH-bit right-shift register, with the new sum bit entering at bit WIDTH-1.
  - carry is a 1-bit flop.
  - cnt is a counter of $clog2(WIDTH) bits.
- State machine (2-bit register): IDLE, RUN, DONE.
- IDLE:
  - IN_READY = 1, OUT_VALID = 0.
  - On IN_VALID=1 at a rising edge (accept):
    - a_sh <= A, b_sh <= B, carry <= CI, cnt <= 0.
    - Go to RUN.
- RUN:
  - IN_READY = 0. Each edge:
    - s_sh <= {addf.S, s_sh[WIDTH-1:1]}.
    - carry <= addf.CO.
    - a_sh and b_sh shift right by one.
    - cnt++.
  - At the edge where cnt == WIDTH-1:
    - S <= final s_sh value (including the current bit) and CO <= addf.CO.
    - Go to DONE.
- DONE:
  - OUT_VALID = 1; S and CO are held.
  - On OUT_READY=1 at an edge, go to IDLE. S and CO keep their value until the next result is loaded.
- IN_VALID outside IDLE is ignored. It is not queued.
- A, B and CI are sampled only at the accept edge. Later changes have no effect.
- OUT_READY outside DONE is ignored.
- IN_READY and OUT_VALID are decoded directly from the state register (glitch-free, no input-to-output combinational path).

## Timing

- Reset (RN low, asynchronous):
  - State = IDLE.
  - S = 0, CO = 0, carry = 0, cnt = 0; a_sh, b_sh and s_sh are cleared.
  - OUT_VALID = 0, IN_READY = 1.
  - Holds while RN is low. Release is synchronous to the first CLK edge with RN high.
- Reset mid-RUN or mid-DONE: the operation is aborted immediately and the result is lost. No OUT_VALID is produced for the aborted operation.
- Latency:
  - Accept edge at cycle 0.
  - OUT_VALID is high after edge WIDTH (WIDTH RUN cycles).
- Throughput: minimum WIDTH+2 cycles per operation (accept, WIDTH RUN cycles, DONE with OUT_READY=1). Back-to-back operation is allowed: IN_READY rises the cycle after the DONE→IDLE edge.
- Backpressure: DONE persists indefinitely while OUT_READY=0. S, CO and OUT_VALID remain stable.
- Carry ripple across all bits behaves identically to the non-ripple case: one bit per cycle, no extra latency.

## Test plan

- Reset:
  - Stimulus: drive RN=0 at an arbitrary time with random inputs.
  - Required: S=0x00, CO=0, OUT_VALID=0, IN_READY=1 asynchronously; no change while RN stays low.
- Basic add (WIDTH=8):
  - Stimulus: A=0x5A, B=0x33, CI=0, IN_VALID pulse, OUT_READY=1.
  - Required: OUT_VALID rises exactly 8 cycles after the accept edge with S=0x8D, CO=0, and is high for 1 cycle. IN_READY=1 on the following cycle.
- Full ripple:
  - Stimulus A: A=0xFF, B=0x01, CI=0.
  - Required A: S=0x00, CO=1.
  - Stimulus B: A=0xFF, B=0xFF, CI=1.
  - Required B: S=0xFF, CO=1.
  - Stimulus C: A=0x00, B=0x00, CI=1.
  - Required C: S=0x01, CO=0.
- Backpressure and ignored input:
  - Stimulus: hold OUT_READY=0 for 5 cycles in DONE, toggle IN_VALID and change A/B during RUN and DONE.
  - Required: S, CO and OUT_VALID stable; IN_READY=0; result matches the values latched at the accept edge. OUT_READY=1 returns the block to IDLE.
- Reset mid-operation:
  - Stimulus: assert RN low 3 cycles into RUN (A=0xAA, B=0x55), then release, then issue A=0x01, B=0x02, CI=1.
  - Required: outputs at reset values, no spurious OUT_VALID; the new operation yields S=0x04, CO=0.
- Randomized back-to-back:
  - Stimulus: 1000 random {A,B,CI} operations with random OUT_READY stalls.
  - Required: every result equals the reference sum A+B+CI, and the count of OUT_VALID/OUT_READY handshakes equals the count of accepted inputs.

Source files
------------

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__addf_serial.sv
// Bit-serial adder: one full-adder slice consumes an operand bit pair per clock, LSB first,
// with valid/ready handshakes on the operand and result sides.

module gf180mcu_fd_sc_mcu9t5v0__addf_serial_slice (
  input  logic A,
  input  logic B,
  input  logic CI,
  output logic S,
  output logic CO
);
  assign S  = A ^ B ^ CI;
  assign CO = (A & B) | (CI & (A ^ B));
endmodule

module gf180mcu_fd_sc_mcu9t5v0__addf_serial #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CI,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] S,
  output logic             CO
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] s_sh_q, s_sh_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             co_q, co_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sum_bit_s;
  logic             co_bit_s;

  gf180mcu_fd_sc_mcu9t5v0__addf_serial_slice u_addf (
    .A  (a_sh_q[0]),
    .B  (b_sh_q[0]),
    .CI (carry_q),
    .S  (sum_bit_s),
    .CO (co_bit_s)
  );

  // Handshake flags come straight off the state register, never from inputs.
  assign IN_READY  = (state_q == ST_IDLE);
  assign OUT_VALID = (state_q == ST_DONE);
  assign S         = s_q;
  assign CO        = co_q;

  // Next-state and datapath: load on accept, shift one bit per RUN cycle, publish on the last bit.
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    s_sh_d  = s_sh_q;
    s_d     = s_q;
    co_d    = co_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (IN_VALID) begin
          a_sh_d  = A;
          b_sh_d  = B;
          carry_d = CI;
          cnt_d   = '0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        s_sh_d  = {sum_bit_s, s_sh_q[WIDTH-1:1]};
        carry_d = co_bit_s;
        a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          // The final bit is still in flight, so take it from the slice, not from s_sh_q.
          s_d     = {sum_bit_s, s_sh_q[WIDTH-1:1]};
          co_d    = co_bit_s;
          state_d = ST_DONE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        if (OUT_READY) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q <= ST_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      s_sh_q  <= '0;
      s_q     <= '0;
      co_q    <= 1'b0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      s_sh_q  <= s_sh_d;
      s_q     <= s_d;
      co_q    <= co_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule
